axil_reg_slave: RTL
===================

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 Parameter NUM_REGS, default 8, count of 32-bit registers; power of two, 2..256.
REQ-002 Parameter RESET_VAL, default 32'h0, reset value of every register.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 S_AXI_AWADDR  in  32  write address.
REQ-006 S_AXI_AWVALID  in  1  write address valid.
REQ-007 S_AXI_AWREADY  out  1  write address ready.
REQ-008 S_AXI_WDATA  in  32  write data.
REQ-009 S_AXI_WSTRB  in  4  byte enables; bit i enables WDATA[8i+7:8i].
REQ-010 S_AXI_WVALID  in  1  write data valid.
REQ-011 S_AXI_WREADY  out  1  write data ready.
REQ-012 S_AXI_BRESP  out  2  write response; OKAY=00, SLVERR=10.
REQ-013 S_AXI_BVALID  out  1  write response valid.
REQ-014 S_AXI_BREADY  in  1  write response ready.
REQ-015 S_AXI_ARADDR  in  32  read address.
REQ-016 S_AXI_ARVALID  in  1  read address valid.
REQ-017 S_AXI_ARREADY  out  1  read address ready.
REQ-018 S_AXI_RDATA  out  32  read data.
REQ-019 S_AXI_RRESP  out  2  read response.
REQ-020 S_AXI_RVALID  out  1  read data valid.
REQ-021 S_AXI_RREADY  in  1  read data ready.
REQ-022 reg_q  out  32*NUM_REGS  flat register contents; register k at [32k+31:32k].
REQ-023 wr_pulse  out  NUM_REGS  one-cycle strobe; bit k high the cycle after register k is written.

Function
REQ-024 Decode: index = ADDR[2 +: log2(NUM_REGS)]; ADDR[1:0] ignored; in range iff ADDR[31:2] < NUM_REGS.
REQ-025 Write FSM states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP; AWREADY high in W_IDLE/W_HAVE_W, WREADY high in W_IDLE/W_HAVE_AW; both low in W_RESP.
REQ-026 AW and W accepted in either order or same cycle; first arriving one is held in a register until the other arrives.
REQ-027 On the edge completing both handshakes: in-range register updated byte-wise per WSTRB, BRESP set, BVALID=1 next cycle, FSM to W_RESP.
REQ-028 W_RESP -> W_IDLE on BVALID&&BREADY; BVALID/BRESP stable until then.
REQ-029 Read FSM states R_IDLE, R_RESP; ARREADY=1 only in R_IDLE; on AR handshake RDATA/RRESP registered, RVALID=1 next cycle.
REQ-030 R_RESP -> R_IDLE on RVALID&&RREADY; RDATA/RRESP stable while RVALID high and RREADY low.
REQ-031 Read and write committing on the same edge to the same register: RDATA returns the pre-write value.
REQ-032 WSTRB=0000 on in-range address: no register change, BRESP=OKAY, wr_pulse still asserted.
REQ-033 Read and write paths are independent; neither stalls the other.

Reset
REQ-034 During rst: all registers = RESET_VAL; AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse = 0; BRESP, RRESP, RDATA = 0; both FSMs idle.
REQ-035 Reset mid-transaction discards held AW/W and pending responses; no partial register write.

Configuration
REQ-036 Macro AXIL_REG_SLAVE_SLVERR_EN defined: out-of-range write ignored with BRESP=SLVERR; out-of-range read returns RDATA=32'hDEADBEEF, RRESP=SLVERR.
REQ-037 Macro undefined: out-of-range write ignored with BRESP=OKAY; out-of-range read returns RDATA=0, RRESP=OKAY.

Structure
REQ-038 Package axil_pkg holds AXI response constants (RESP_OKAY, RESP_SLVERR) and write/read FSM state enums.
REQ-039 Single module, no sub-modules.

Verification
REQ-040 AW 0x04 and W 0x12345678/1111 same cycle -> BVALID next cycle, BRESP=00, reg 1 = 0x12345678, wr_pulse[1] one cycle.
REQ-041 W 0xAABBCCDD/0101 two cycles before AW 0x08 -> reg 2 = RESET_VAL with bytes 0 and 2 replaced by DD and BB.
REQ-042 Read 0x04 with RREADY held low 3 cycles -> RVALID and RDATA=0x12345678 stable 4 cycles, ARREADY low throughout.
REQ-043 Write 0x40 (NUM_REGS=8) -> no register change; BRESP=10 with macro, 00 without; read 0x40 -> DEADBEEF/10 or 0/00.
REQ-044 Read of reg 3 and write 0x55 to reg 3 committing the same edge -> RDATA = old value; later read returns 0x55.
REQ-045 rst asserted with W held, AW pending -> all outputs 0; after release, AW alone produces no BVALID.

Source files
------------

// File: rtl/axil_pkg.sv
// AXI4-Lite response codes and FSM state types shared by axil_reg_slave.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with byte strobes and per-register write pulses.
// Define AXIL_REG_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR (reads return 32'hDEADBEEF).
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 8,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              S_AXI_AWADDR,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [31:0]              S_AXI_ARADDR,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [29:0] NUM_REGS_W = 30'(NUM_REGS);

`ifdef AXIL_REG_SLAVE_SLVERR_EN
    localparam logic [1:0]  OOR_RESP  = RESP_SLVERR;
    localparam logic [31:0] OOR_RDATA = 32'hDEADBEEF;
`else
    localparam logic [1:0]  OOR_RESP  = RESP_OKAY;
    localparam logic [31:0] OOR_RDATA = 32'h0;
`endif

    wr_state_e           wr_state_q, wr_state_d;
    rd_state_e           rd_state_q, rd_state_d;
    logic [29:0]         aw_word_q, aw_word_d;
    logic [31:0]         w_data_q, w_data_d;
    logic [3:0]          w_strb_q, w_strb_d;
    logic [1:0]          bresp_q;
    logic [31:0]         rdata_q;
    logic [1:0]          rresp_q;
    logic [NUM_REGS-1:0] wr_pulse_q;
    logic [31:0]         regs_q [NUM_REGS];

    logic                commit;
    logic [29:0]         c_word;
    logic [31:0]         c_data;
    logic [3:0]          c_strb;
    logic                c_in_range;
    logic [IDX_W-1:0]    c_idx;
    logic                aw_rdy, w_rdy, ar_fire, ar_in_range;
    logic [IDX_W-1:0]    ar_idx;
    logic                unused_addr_lsbs;

    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // NOTE: combinational blocks assign every output a default first so no latch can be inferred.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_word_d  = aw_word_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        aw_rdy     = 1'b0;
        w_rdy      = 1'b0;
        commit     = 1'b0;
        c_word     = aw_word_q;
        c_data     = w_data_q;
        c_strb     = w_strb_q;
        case (wr_state_q)
            W_IDLE: begin
                aw_rdy = 1'b1;
                w_rdy  = 1'b1;
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    commit = 1'b1;
                    c_word = S_AXI_AWADDR[31:2];
                    c_data = S_AXI_WDATA;
                    c_strb = S_AXI_WSTRB;
                end else if (S_AXI_AWVALID) begin
                    aw_word_d  = S_AXI_AWADDR[31:2];
                    wr_state_d = W_HAVE_AW;
                end else if (S_AXI_WVALID) begin
                    w_data_d   = S_AXI_WDATA;
                    w_strb_d   = S_AXI_WSTRB;
                    wr_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                w_rdy = 1'b1;
                if (S_AXI_WVALID) begin
                    commit = 1'b1;
                    c_data = S_AXI_WDATA;
                    c_strb = S_AXI_WSTRB;
                end
            end
            W_HAVE_W: begin
                aw_rdy = 1'b1;
                if (S_AXI_AWVALID) begin
                    commit = 1'b1;
                    c_word = S_AXI_AWADDR[31:2];
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (commit) wr_state_d = W_RESP;
    end

    assign c_in_range = (c_word < NUM_REGS_W);
    assign c_idx      = c_word[IDX_W-1:0];

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            aw_word_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_word_q  <= aw_word_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            wr_pulse_q <= '0;
            if (commit) begin
                bresp_q <= c_in_range ? RESP_OKAY : OOR_RESP;
                if (c_in_range) wr_pulse_q[c_idx] <= 1'b1;
            end
        end
    end

    // NOTE: the register array is reset because software relies on RESET_VAL being observable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
        end else if (commit && c_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (c_strb[b]) regs_q[c_idx][8*b +: 8] <= c_data[8*b +: 8];
            end
        end
    end

    assign ar_fire     = (rd_state_q == R_IDLE) && S_AXI_ARVALID;
    assign ar_in_range = (S_AXI_ARADDR[31:2] < NUM_REGS_W);
    assign ar_idx      = S_AXI_ARADDR[2 +: IDX_W];

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (S_AXI_ARVALID) rd_state_d = R_RESP;
            R_RESP:  if (S_AXI_RREADY)  rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Sampling regs_q before this edge's write lands gives a colliding read the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_fire) begin
                rdata_q <= ar_in_range ? regs_q[ar_idx] : OOR_RDATA;
                rresp_q <= ar_in_range ? RESP_OKAY : OOR_RESP;
            end
        end
    end

    // Readies are masked so nothing is offered to the master while reset is held.
    assign S_AXI_AWREADY = aw_rdy & ~rst;
    assign S_AXI_WREADY  = w_rdy & ~rst;
    assign S_AXI_ARREADY = (rd_state_q == R_IDLE) & ~rst;
    assign S_AXI_BVALID  = (wr_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = (rd_state_q == R_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign reg_q[32*k +: 32] = regs_q[k];
    end

endmodule
